// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: opcode constants, data width and the
// fetch FSM state encoding used by instr_fetch.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LUI  = 7'b0110111;
   localparam logic [6:0] OPC_LW   = 7'b0000011;
   localparam logic [6:0] OPC_SW   = 7'b0100011;
   localparam logic [6:0] OPC_BR   = 7'b1100011;
   localparam logic [6:0] OPC_HALT = 7'b0000000;

   typedef enum logic [1:0] {
      ST_REQ    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   function automatic logic is_halt(input logic [XLEN-1:0] instr);
      return instr[6:0] == OPC_HALT;
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: power-of-two deep FIFO of {pc, instr} pairs with
// synchronous flush. Push while full is accepted when a pop happens in the
// same cycle. Storage is not reset; only the pointers are.
module fetch_buf
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            push,
   input  logic [XLEN-1:0] push_pc,
   input  logic [XLEN-1:0] push_instr,
   input  logic            pop,
   output logic [XLEN-1:0] head_pc,
   output logic [XLEN-1:0] head_instr,
   output logic            full,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] instr_mem_q [DEPTH];
   logic            do_push, do_pop;

   // Occupancy flags, accepted push/pop and next pointer values
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop) && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      head_pc    = pc_mem_q[rd_ptr_q[AW-1:0]];
      head_instr = instr_mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage, written at the tail on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem_q[wr_ptr_q[AW-1:0]]    <= push_pc;
         instr_mem_q[wr_ptr_q[AW-1:0]] <= push_instr;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory request, in-order responses
// buffered in fetch_buf, redirect flushes and drops any in-flight response.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        halted
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         drop_q, drop_d;
   logic         live_q, live_d;

   logic         buf_full, buf_empty;
   logic [31:0]  head_pc, head_instr;
   logic         req_fire, rsp_take, push, pop, halt_hit;

   fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect),
      .push       (push),
      .push_pc    (pc_q - 32'd4),
      .push_instr (imem_rsp_data),
      .pop        (pop),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   // Handshakes and outputs; live_q holds requests off for the first cycle after reset
   always_comb begin
      imem_req_valid = live_q && (state_q == ST_REQ) && !drop_q && !buf_full;
      imem_req_addr  = pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_take       = (state_q == ST_WAIT) && imem_rsp_valid;
      push           = rsp_take && !redirect;
      id_valid       = !buf_empty;
      pop            = id_valid && id_ready && !redirect;
      id_instr       = buf_empty ? 32'h0 : head_instr;
      id_pc          = buf_empty ? 32'h0 : head_pc;
`ifdef FETCH_HALT_DETECT_EN
      halt_hit       = push && is_halt(imem_rsp_data);
      halted         = (state_q == ST_HALTED) && buf_empty;
`else
      halt_hit       = 1'b0;
      halted         = 1'b0;
`endif
   end

   // Next-state logic; redirect overrides response, halt and request progress
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      live_d  = 1'b1;
      if (redirect) begin
         state_d = ST_REQ;
         pc_d    = redirect_pc & ~32'h3;
         // A response is still owed if one was outstanding and has not just
         // arrived, or if a request is being accepted on this very edge.
         drop_d  = (((state_q == ST_WAIT) || drop_q) && !imem_rsp_valid) || req_fire;
      end else begin
         case (state_q)
            ST_REQ: begin
               if (drop_q && imem_rsp_valid) drop_d = 1'b0;
               if (req_fire) begin
                  state_d = ST_WAIT;
                  pc_d    = pc_q + 32'd4;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) state_d = halt_hit ? ST_HALTED : ST_REQ;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_REQ;
         endcase
      end
   end

   // FSM and fetch-control registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         live_q  <= live_d;
      end
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_rsp_valid  input  1  instruction word returned, one per accepted request, in order.
REQ-009 imem_rsp_data  input  32  returned instruction.
REQ-010 id_valid  output  1  instruction available to decode.
REQ-011 id_ready  input  1  decode consumes head instruction.
REQ-012 id_instr  output  32  head instruction; bits [6:0] drive the decode opcode input.
REQ-013 id_pc  output  32  address of id_instr.
REQ-014 redirect  input  1  branch taken; refetch from redirect_pc.
REQ-015 redirect_pc  input  32  target address; bits [1:0] ignored, treated as zero.
REQ-016 halted  output  1  fetch stopped on halt opcode.

Function
REQ-017 FSM states: REQ (request pending), WAIT (one request outstanding), HALTED.
REQ-018 At most one request outstanding; imem_req_valid asserted only in REQ with a free buffer slot counting the in-flight entry.
REQ-019 REQ->WAIT on imem_req_valid && imem_req_ready; pc advances by 4 on the same edge (32-bit wrap from 32'hFFFF_FFFC to 0).
REQ-020 WAIT->REQ on imem_rsp_valid; response written to buffer with its pc; id_valid rises the following cycle (1-cycle rsp-to-decode latency).
REQ-021 Buffer FIFO: head pops on id_valid && id_ready; push and pop in the same cycle allowed at any occupancy, including full.
REQ-022 imem_req_addr and imem_req_valid held stable while imem_req_valid && !imem_req_ready.
REQ-023 redirect: same edge flushes buffer (id_valid 0 next cycle), loads pc <= redirect_pc, enters REQ; if in WAIT, the outstanding response is dropped via a drop flag and the next request waits for it to return.
REQ-024 redirect has priority over push, pop and halt detection in the same cycle.
REQ-025 imem_rsp_valid outside WAIT (except while dropping) is ignored.

Reset
REQ-026 On reset low: pc=RESET_PC, state=REQ, buffer empty, drop flag 0; imem_req_valid=0, id_valid=0, halted=0, imem_req_addr=RESET_PC, id_instr=0, id_pc=0.
REQ-027 Reset asserted mid-WAIT discards the outstanding transaction; the first request follows one cycle after reset release.

Configuration
REQ-028 Macro FETCH_HALT_DETECT_EN defined: a pushed instruction with opcode 7'b0000000 moves FSM to HALTED; no further requests; halted=1 once buffer drains; halt instruction itself still delivered to decode; redirect exits HALTED to REQ and clears halted.
REQ-029 Macro undefined: no HALTED state; opcode 7'b0000000 fetched like any other; halted tied 0.

Structure
REQ-030 Shared package riscv_pkg holds opcode constants (OPC_R, OPC_I, OPC_LUI, OPC_LW, OPC_SW, OPC_BR, OPC_HALT), XLEN=32, and the fetch state enum.
REQ-031 Buffer is sub-module fetch_buf (parameterised-depth FIFO of {pc, instr}) with full/empty outputs.

Verification
REQ-032 Reset release, imem_req_ready=1, rsp one cycle later with 32'h00500093 -> addr 0 then 4; id_valid with id_pc=0, id_instr=32'h00500093 one cycle after rsp.
REQ-033 id_ready=0 for 10 cycles -> exactly BUF_DEPTH=2 instructions buffered, no third request issued; id_ready=1 resumes at addr 8.
REQ-034 redirect=1, redirect_pc=32'h0000_0040 during WAIT -> in-flight rsp dropped, next request addr 32'h40, first id_pc=32'h40.
REQ-035 Stall imem_req_ready=0 for 3 cycles -> imem_req_addr stable, single request accepted.
REQ-036 FETCH_HALT_DETECT_EN, rsp 32'h00000000 at pc 8 -> halt instr delivered, halted=1, no requests; redirect to 32'h0 -> halted=0, fetch restarts at 0.
REQ-037 Reset low during WAIT, late rsp after release -> ignored; first request at RESET_PC.
